// File: rtl/loop_seq_if.sv
// Bundle of the loop sequencer's control and index-stream signals.
// The slave modport is the sequencer's view; master is the controller/consumer view.
// Optional iteration counter is present when LOOP_SEQ_ITER_CNT_EN is defined.
interface loop_seq_if #(
  parameter int unsigned IDX_W = 32
);
  logic             start;
  logic [IDX_W-1:0] first;
  logic [IDX_W-1:0] bound;
  logic [IDX_W-1:0] step;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             brk;
  logic             busy;
  logic             done;
  logic             broke;
`ifdef LOOP_SEQ_ITER_CNT_EN
  logic [IDX_W-1:0] iter_cnt;
`endif

  modport master (
    output start, first, bound, step, out_ready, brk,
`ifdef LOOP_SEQ_ITER_CNT_EN
    input  iter_cnt,
`endif
    input  out_valid, out_idx, out_last, busy, done, broke
  );

  modport slave (
    input  start, first, bound, step, out_ready, brk,
`ifdef LOOP_SEQ_ITER_CNT_EN
    output iter_cnt,
`endif
    output out_valid, out_idx, out_last, busy, done, broke
  );
endinterface

// File: rtl/loop_sequencer.sv
// Hardware for-loop index generator: for (i = first; i < bound; i += step) with break.
// Issues one index per valid/ready beat, pulses done for one cycle on completion.
// Optional feature macro: LOOP_SEQ_ITER_CNT_EN adds the iter_cnt beat counter.
module loop_sequencer #(
  parameter int unsigned IDX_W    = 32,
  parameter int unsigned MIN_STEP = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  loop_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] cur_q;
  logic [IDX_W-1:0] bound_q;
  logic [IDX_W-1:0] step_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             broke_q;
  logic [IDX_W:0]   next_idx;
  logic             last;
  logic             beat;

  // Carry bit of next_idx forces last so the index can never wrap below bound.
  always_comb begin
    next_idx = {1'b0, cur_q} + {1'b0, step_q};
    last     = (state_q == StRun) && (next_idx >= {1'b0, bound_q});
    beat     = valid_q && bus.out_ready;
  end

`ifdef LOOP_SEQ_ITER_CNT_EN
  logic [IDX_W-1:0] iter_cnt_q;

  // Counts accepted beats, including a breaking one; cleared on accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt_q <= '0;
    end else if (state_q == StIdle && bus.start) begin
      iter_cnt_q <= '0;
    end else if (beat) begin
      iter_cnt_q <= iter_cnt_q + 1'b1;
    end
  end

  assign bus.iter_cnt = iter_cnt_q;
`endif

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      bound_q <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      broke_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            cur_q   <= bus.first;
            bound_q <= bus.bound;
            step_q  <= (bus.step == '0) ? IDX_W'(MIN_STEP) : bus.step;
            broke_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.first >= bus.bound) begin
              // Empty loop: no beats, straight to the done pulse.
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              valid_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (beat) begin
            if (bus.brk || last) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              broke_q <= bus.brk;
            end else begin
              cur_q <= next_idx[IDX_W-1:0];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_idx   = cur_q;
  assign bus.out_last  = last;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.broke     = broke_q;

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Hardware loop-index generator for a for-loop, equivalent to `for (i = first; i < bound; i += step)`, with early-exit (break) support.
- Sits directly upstream of a loop-body consumer and issues one index per valid/ready beat.
- The consumer can terminate the loop on any accepted beat, mirroring a break out of the loop body.
- Completion is reported with a single-cycle done pulse.

Parameters:
- IDX_W, 32, width of loop index, first, bound and step (unsigned).
- MIN_STEP, 1, value substituted when step input is 0 (prevents infinite loop).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- first  input  IDX_W  initial index, latched on accepted start.
- bound  input  IDX_W  exclusive upper bound, latched on accepted start.
- step  input  IDX_W  increment, latched on accepted start; 0 is replaced by MIN_STEP.
- out_valid  output  1  index beat valid.
- out_ready  input  1  consumer ready.
- out_idx  output  IDX_W  current index.
- out_last  output  1  current beat is the final natural iteration.
- brk  input  1  break request; honoured only on a beat where out_valid && out_ready.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- broke  output  1  high with done when termination was caused by brk; held until next accepted start.

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_valid=0, out_idx=0, out_last=0, busy=0, done=0, broke=0; latched first/bound/step=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches first/bound/step and clears broke.
  - If first >= bound (unsigned), go to DONE; zero iterations, no beats issued.
  - Otherwise go to RUN with cur=first.
  - Latency start->first out_valid: 1 cycle.
- RUN:
  - out_valid=1, out_idx=cur.
  - next = cur + step, computed in IDX_W+1 bits.
  - out_last = (next >= bound) || next[IDX_W] (carry). Combinational from registered state.
  - Beat (out_valid && out_ready) with brk=1: go to DONE, set broke=1. out_idx does not advance.
  - Beat with brk=0 and out_last=1: go to DONE.
  - Beat with brk=0 and out_last=0: cur <= next[IDX_W-1:0]; stay in RUN.
  - No beat: hold out_idx, out_valid and out_last stable (AXI-style; valid never drops before the beat).
  - brk while out_ready=0 is ignored.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, then IDLE.
  - busy drops in the cycle done drops.
- start while busy is ignored and not queued.
- start in the same cycle done is high is ignored; earliest restart is the cycle after done.
- Wrap-around: carry out of IDX_W forces out_last. The index never wraps back below bound.
- Reset mid-RUN: immediate return to IDLE, no done pulse.
- Throughput: one index per cycle while out_ready is held high.
- Iteration count: ceil((bound-first)/step) beats when not broken.

Optional Feature:
- Macro LOOP_SEQ_ITER_CNT_EN.
- When defined, adds output iter_cnt [IDX_W], which:
  - clears on accepted start;
  - increments on every accepted beat, including the breaking beat;
  - holds its value after done until the next start;
  - resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- first=0, bound=10, step=1, out_ready=1: beats idx 0..9 on consecutive cycles; out_last only on 9; done pulse one cycle after beat 9; broke=0.
- first=0, bound=10, step=1, brk=1 on beat with idx=4: beats 0..4 only; done next cycle; broke=1; iter_cnt=5 when LOOP_SEQ_ITER_CNT_EN is defined.
- first=7, bound=7: no out_valid ever; done one cycle after start; first=9, bound=3 gives the same result.
- first=0, bound=5, step=0: step treated as 1; beats 0..4.
- IDX_W=32, first=32'hFFFF_FFFD, bound=32'hFFFF_FFFF, step=4: single beat idx=FFFF_FFFD with out_last=1; no wrap to 1.
- out_ready toggled 1010..., first=0, bound=4, step=2: out_idx held stable while stalled; beats 0 and 2 only.
- Reset asserted mid-RUN at idx=3: out_valid and busy drop asynchronously; no done pulse.
- start re-pulsed while busy: ignored; the current loop completes unchanged.
